// File: rtl/image_byte_streamer.sv
`default_nettype none
// ============================================================================
// Module   : image_byte_streamer
// Purpose  : Captures a packed numBytes-wide image word and streams it LSB byte
//            first over valid/ready. Define IMAGE_STREAM_CHECKSUM_EN to append
//            a mod-256 checksum beat after the data bytes.
// Revision : 1.0 - initial release
// ============================================================================
module image_byte_streamer #(
   parameter  int numBytes = 25,
   localparam int IDX_W    = $clog2(numBytes + 1)
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    start,
   input  logic [8*numBytes-1:0]   data_in,
   output logic [7:0]              out_data,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic                    out_last,
   output logic                    busy,
   output logic                    done,
   output logic [IDX_W-1:0]        byte_idx
);

   localparam int c_NUM_SLOTS = 1 << IDX_W;
`ifdef IMAGE_STREAM_CHECKSUM_EN
   localparam logic [IDX_W-1:0] c_LAST_IDX = IDX_W'(numBytes);
`else
   localparam logic [IDX_W-1:0] c_LAST_IDX = IDX_W'(numBytes - 1);
`endif

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_STREAM = 2'd1,
      S_DONE   = 2'd2
   } state_t;

   state_t                  r_state;
   state_t                  w_state_nxt;
   logic [8*numBytes-1:0]   r_cap;
   logic [IDX_W-1:0]        r_idx;
   logic                    w_capture;
   logic                    w_beat;
   logic                    w_at_last;
   logic [7:0]              w_slot [c_NUM_SLOTS];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_capture   = 1'b0;
      out_valid   = 1'b0;
      busy        = 1'b0;
      done        = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (start) begin
               w_capture   = 1'b1;
               w_state_nxt = S_STREAM;
            end
         end
         S_STREAM: begin
            out_valid = 1'b1;
            busy      = 1'b1;
            if (out_ready && w_at_last) begin
               w_state_nxt = S_DONE;
            end
         end
         S_DONE: begin
            busy        = 1'b1;
            done        = 1'b1;
            w_state_nxt = S_IDLE;
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   assign w_at_last = (r_idx == c_LAST_IDX);
   assign w_beat    = out_valid & out_ready;
   assign out_last  = out_valid & w_at_last;
   assign out_data  = out_valid ? w_slot[r_idx] : 8'h00;
   assign byte_idx  = r_idx;

   // Index stops on the final beat so it never walks past the slot table.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_cap <= '0;
         r_idx <= '0;
      end else if (w_capture) begin
         r_cap <= data_in;
         r_idx <= '0;
      end else if (w_beat && !w_at_last) begin
         r_idx <= r_idx + 1'b1;
      end
   end

`ifdef IMAGE_STREAM_CHECKSUM_EN
   logic [7:0] w_sum;
   logic [7:0] r_sum;

   always_comb begin
      w_sum = 8'h00;
      for (int k = 0; k < numBytes; k++) begin
         w_sum = w_sum + data_in[8*k +: 8];
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_sum <= 8'h00;
      end else if (w_capture) begin
         r_sum <= w_sum;
      end
   end
`endif

   // Slot table sized to a power of two so r_idx indexes it at full width.
   for (genvar k = 0; k < c_NUM_SLOTS; k++) begin : g_slot
      if (k < numBytes) begin : g_data
         assign w_slot[k] = r_cap[8*k +: 8];
      end else if (k == numBytes) begin : g_sum
`ifdef IMAGE_STREAM_CHECKSUM_EN
         assign w_slot[k] = r_sum;
`else
         assign w_slot[k] = 8'h00;
`endif
      end else begin : g_pad
         assign w_slot[k] = 8'h00;
      end
   end

endmodule
`default_nettype wire
